// File: rtl/mcr3_rom_loader_if.sv
// -----------------------------------------------------------------------------
// mcr3_rom_loader_if
// Bundles every signal the MCR3 ROM loader exchanges with the outside world:
//   - hps_io download stream : ioctl_download, ioctl_index, ioctl_wr,
//                              ioctl_addr, ioctl_dout, ioctl_wait
//   - SDRAM port1 (main/snd) : port1_req/ack toggle pair, port1_a/ds/d
//   - SDRAM port2 (sprites)  : port2_req/ack toggle pair, port2_a/ds/d
//   - core background bus    : dl_wr, dl_addr, dl_data
//   - status                 : rom_loaded, error
// Modport master is the loader itself (it masters the SDRAM and dl_* writes);
// modport slave is the environment (hps_io, SDRAM controller, core).
// -----------------------------------------------------------------------------
interface mcr3_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        port2_req;
  logic        port2_ack;
  logic [17:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  logic        dl_wr;
  logic [14:0] dl_addr;
  logic [7:0]  dl_data;

  logic        rom_loaded;
  logic        error;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output port1_req, port1_a, port1_ds, port1_d,
    input  port1_ack,
    output port2_req, port2_a, port2_ds, port2_d,
    input  port2_ack,
    output dl_wr, dl_addr, dl_data,
    output rom_loaded, error
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  port1_req, port1_a, port1_ds, port1_d,
    output port1_ack,
    input  port2_req, port2_a, port2_ds, port2_d,
    output port2_ack,
    input  dl_wr, dl_addr, dl_data,
    input  rom_loaded, error
  );
endinterface

// File: rtl/mcr3_rom_loader.sv
// -----------------------------------------------------------------------------
// mcr3_rom_loader
// Steers the hps_io index-0 ROM download into the MCR3 memories:
//   main/sound ROM -> SDRAM port1, sprite ROM -> SDRAM port2 (address
//   scrambled to the sprite layout), background ROM -> core dl_* bus.
// SDRAM writes use a toggle req/ack handshake; ioctl_wait stalls hps_io until
// the ack arrives or ACK_TIMEOUT expires (which raises the sticky error).
// Ports:
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : mcr3_rom_loader_if.master (download, port1, port2, dl, status)
// -----------------------------------------------------------------------------
module mcr3_rom_loader #(
  parameter logic [24:0] SP_BASE     = 25'h12000,
  parameter logic [24:0] BG_BASE     = 25'h32000,
  parameter logic [24:0] ROM_END     = 25'h3A000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic              clk_sys,
  input  logic              reset,
  mcr3_rom_loader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;          // 0: port1 transfer, 1: port2 transfer
  logic [7:0]  cnt_q, cnt_d;
  logic        p1_req_q, p1_req_d;
  logic [22:0] p1_a_q, p1_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d;
  logic [15:0] p1_d_q, p1_d_d;
  logic        p2_req_q, p2_req_d;
  logic [17:0] p2_a_q, p2_a_d;
  logic [1:0]  p2_ds_q, p2_ds_d;
  logic [15:0] p2_d_q, p2_d_d;
  logic        dl_wr_q, dl_wr_d;
  logic [14:0] dl_addr_q, dl_addr_d;
  logic [7:0]  dl_data_q, dl_data_d;
  logic        dl_act_q, dl_act_d;
  logic        saw_last_q, saw_last_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        error_q, error_d;

  logic        dl_act, wr_ok, in_rom, accept;
  logic        is_p1, is_p2, is_bg;
  logic        ack_match, timeout;
  logic [24:0] sp_off, bg_off;
  logic        unused_bits;

  assign dl_act = bus.ioctl_download && (bus.ioctl_index == 8'd0);
  assign wr_ok  = bus.ioctl_wr && dl_act;
  assign in_rom = bus.ioctl_addr < ROM_END;
  assign accept = wr_ok && in_rom && (state_q == S_IDLE);

  assign is_p1  = bus.ioctl_addr < SP_BASE;
  assign is_p2  = (bus.ioctl_addr >= SP_BASE) && (bus.ioctl_addr < BG_BASE);
  assign is_bg  = (bus.ioctl_addr >= BG_BASE) && in_rom;

  assign sp_off = bus.ioctl_addr - SP_BASE;
  assign bg_off = bus.ioctl_addr - BG_BASE;
  assign unused_bits = ^{sp_off[24:19], bg_off[24:15]};

  // The transfer is complete once the selected ack has caught up with its req.
  assign ack_match = sel_q ? (bus.port2_ack == p2_req_q) : (bus.port1_ack == p1_req_q);
  assign timeout   = (cnt_q + 8'd1) == ACK_TIMEOUT;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = '0;
    p1_req_d     = p1_req_q;
    p1_a_d       = p1_a_q;
    p1_ds_d      = p1_ds_q;
    p1_d_d       = p1_d_q;
    p2_req_d     = p2_req_q;
    p2_a_d       = p2_a_q;
    p2_ds_d      = p2_ds_q;
    p2_d_d       = p2_d_q;
    dl_wr_d      = 1'b0;
    dl_addr_d    = dl_addr_q;
    dl_data_d    = dl_data_q;
    dl_act_d     = dl_act;
    saw_last_d   = saw_last_q;
    rom_loaded_d = rom_loaded_q;
    error_d      = error_q;

    // Download start clears status; the later set terms below take priority.
    if (dl_act && !dl_act_q) begin
      rom_loaded_d = 1'b0;
      error_d      = 1'b0;
      saw_last_d   = 1'b0;
    end
    if (!dl_act && dl_act_q)
      rom_loaded_d = !error_q && saw_last_q;

    if (accept && (bus.ioctl_addr == ROM_END - 25'd1))
      saw_last_d = 1'b1;

    // A strobe while a transfer is in flight is dropped and flagged.
    if (wr_ok && (state_q != S_IDLE))
      error_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept && is_p1) begin
          p1_a_d  = bus.ioctl_addr[23:1];
          p1_ds_d = {bus.ioctl_addr[0], ~bus.ioctl_addr[0]};
          p1_d_d  = {bus.ioctl_dout, bus.ioctl_dout};
          sel_d   = 1'b0;
          state_d = S_REQ;
        end else if (accept && is_p2) begin
          // Sprite layout: S[16] becomes the word LSB, S[15] picks the byte lane.
          p2_a_d  = {sp_off[18:17], sp_off[14:0], sp_off[16]};
          p2_ds_d = {sp_off[15], ~sp_off[15]};
          p2_d_d  = {bus.ioctl_dout, bus.ioctl_dout};
          sel_d   = 1'b1;
          state_d = S_REQ;
        end else if (accept && is_bg) begin
          dl_wr_d   = 1'b1;
          dl_addr_d = bg_off[14:0];
          dl_data_d = bus.ioctl_dout;
        end
      end
      S_REQ: begin
        if (sel_q) p2_req_d = ~p2_req_q;
        else       p1_req_d = ~p1_req_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (ack_match) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      p1_req_q     <= 1'b0;
      p1_a_q       <= '0;
      p1_ds_q      <= '0;
      p1_d_q       <= '0;
      p2_req_q     <= 1'b0;
      p2_a_q       <= '0;
      p2_ds_q      <= '0;
      p2_d_q       <= '0;
      dl_wr_q      <= 1'b0;
      dl_addr_q    <= '0;
      dl_data_q    <= '0;
      dl_act_q     <= 1'b0;
      saw_last_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      p1_req_q     <= p1_req_d;
      p1_a_q       <= p1_a_d;
      p1_ds_q      <= p1_ds_d;
      p1_d_q       <= p1_d_d;
      p2_req_q     <= p2_req_d;
      p2_a_q       <= p2_a_d;
      p2_ds_q      <= p2_ds_d;
      p2_d_q       <= p2_d_d;
      dl_wr_q      <= dl_wr_d;
      dl_addr_q    <= dl_addr_d;
      dl_data_q    <= dl_data_d;
      dl_act_q     <= dl_act_d;
      saw_last_q   <= saw_last_d;
      rom_loaded_q <= rom_loaded_d;
      error_q      <= error_d;
    end
  end

  // Stall drops in the very cycle the ack matches so hps_io resumes at once.
  assign bus.ioctl_wait = (state_q == S_REQ) || ((state_q == S_WAIT) && !ack_match);
  assign bus.port1_req  = p1_req_q;
  assign bus.port1_a    = p1_a_q;
  assign bus.port1_ds   = p1_ds_q;
  assign bus.port1_d    = p1_d_q;
  assign bus.port2_req  = p2_req_q;
  assign bus.port2_a    = p2_a_q;
  assign bus.port2_ds   = p2_ds_q;
  assign bus.port2_d    = p2_d_q;
  assign bus.dl_wr      = dl_wr_q;
  assign bus.dl_addr    = dl_addr_q;
  assign bus.dl_data    = dl_data_q;
  assign bus.rom_loaded = rom_loaded_q;
  assign bus.error      = error_q;

endmodule

// File: doc/mcr3_rom_loader.md
Name: mcr3_rom_loader

Overview:
- Sequences the ROM download stream from hps_io into the MCR3 core's memories.
- Routes each byte by address region: main and sound ROM go to SDRAM port1, sprite ROM goes to SDRAM port2, background ROM goes to the core's dl_* bus.
- Uses a full toggle req/ack handshake with the SDRAM controller and holds ioctl_wait until each write completes.
- Flags download completion (rom_loaded) and handshake faults (error) for the top-level reset logic.

Parameters:
- SP_BASE, 25'h12000, first sprite ROM byte address.
- BG_BASE, 25'h32000, first background ROM byte address.
- ROM_END, 25'h3A000, first address past all ROM; writes at or above it are ignored.
- ACK_TIMEOUT, 8'd255, clk_sys cycles to wait for an ack before faulting.

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset  in  1  synchronous active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index; only 0 is handled.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- port1_req  out  1  port1 toggle request.
- port1_ack  in  1  port1 toggle ack.
- port1_a  out  23  port1 word address.
- port1_ds  out  2  port1 byte selects.
- port1_d  out  16  port1 write data.
- port2_req  out  1  port2 toggle request.
- port2_ack  in  1  port2 toggle ack.
- port2_a  out  18  port2 word address.
- port2_ds  out  2  port2 byte selects.
- port2_d  out  16  port2 write data.
- dl_wr  out  1  background write strobe.
- dl_addr  out  15  background byte address.
- dl_data  out  8  background byte data.
- rom_loaded  out  1  download completed cleanly.
- error  out  1  sticky fault flag.

Behaviour:
- Reset state: every output 0 (both req toggles 0, ioctl_wait 0, rom_loaded 0, error 0); FSM in IDLE; timeout counter 0. Reset mid-transfer abandons the transfer; req is forced to 0, so the SDRAM side must also be reset for req and ack to match.
- Accepted write: ioctl_wr=1 while ioctl_download=1, ioctl_index=0 and FSM=IDLE. Writes with any other index, or with address >= ROM_END, are ignored and cause no stall.
- Region decode, with A = ioctl_addr:
  - A < SP_BASE: port1. port1_a = A[23:1], port1_ds = {A[0],~A[0]}, port1_d = {dout,dout}.
  - SP_BASE <= A < BG_BASE: port2, with S = A - SP_BASE. port2_a = {S[18:17],S[14:0],S[16]}, port2_ds = {S[15],~S[15]}, port2_d = {dout,dout}.
  - BG_BASE <= A < ROM_END: dl_wr pulses 1 for exactly the next cycle, with dl_addr = (A - BG_BASE)[14:0] and dl_data = dout. No stall, FSM stays in IDLE.
- Address and data registers are loaded on the accept cycle and held stable until the FSM returns to IDLE.
- FSM states:
  - IDLE: on an accepted port1/port2 write, go to REQ.
  - REQ (1 cycle): toggle the selected req; ioctl_wait=1; go to WAIT.
  - WAIT: ioctl_wait=1; the counter increments each cycle. When the selected ack equals its req, go to IDLE (ioctl_wait drops that cycle). When the counter reaches ACK_TIMEOUT, set error and go to IDLE.
- ioctl_wait: the accept cycle is combinationally 0; wait is 1 for REQ and WAIT. Minimum stall is 2 cycles after the strobe.
- ioctl_wr arriving while FSM != IDLE is a protocol violation: the byte is dropped and error is set.
- An ack toggle with no outstanding request is ignored.
- rom_loaded:
  - Cleared on a rising edge of (ioctl_download & index==0).
  - Set on the falling edge only if error=0 and at least one write at address ROM_END-1 was accepted during that download.
- error: cleared only by reset or by the start of a new index-0 download.
- Simultaneous ack and timeout in the same cycle: the ack wins and error is not set.

Test Plan:
- Write 0x5A at addr 0x00001 -> port1_a=0, port1_ds=2'b10, port1_d=16'h5A5A, port1_req toggles to 1; ack toggled 3 cycles later -> ioctl_wait falls the same cycle, error=0.
- Write at 0x12000+0x18001 -> S=0x18001, port2_a={2'b00,15'h0001,1'b1}=0x3, port2_ds=2'b10; ack -> return to IDLE.
- Write 0xC3 at 0x32010 -> dl_wr=1 for 1 cycle, dl_addr=0x010, dl_data=0xC3; ioctl_wait stays 0 and port req lines are unchanged.
- Port1 write with ack never returned -> error=1 after 255 WAIT cycles, ioctl_wait=0; at the following download end rom_loaded stays 0.
- Full stream 0x00000..0x39FFF with ack after 2 cycles -> rom_loaded=1 on the download falling edge; the next index-0 download start clears it. A write at 0x3A000 is ignored.
- Assert reset during WAIT -> next cycle ioctl_wait=0, port1_req=0, FSM=IDLE, error=0, rom_loaded=0.
